// File: rtl/carga_programa_if.sv
// Byte-stream handshake plus instruction-memory write port of the program loader.
// master: the loader side. slave: the stream source / memory side.
interface carga_programa_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        OpMemIns;
  logic [31:0] endLeitura;
  logic [31:0] instrucao;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output OpMemIns,
    output endLeitura,
    output instrucao
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  OpMemIns,
    input  endLeitura,
    input  instrucao
  );
endinterface

// File: rtl/carga_programa.sv
// Program loader: byte stream in (count, words MSB first, XOR checksum), 32-bit
// instruction-memory writes out, one word per write pulse. All outputs registered.
module carga_programa #(
  parameter int unsigned BASE = 0,
  parameter int unsigned PROF = 16384
) (
  input  logic                    clock_auto,
  input  logic                    reset,
  input  logic                    iniciar,
  carga_programa_if.master        bus,
  output logic                    ocupado,
  output logic                    carga_ok,
  output logic                    erro,
  output logic [15:0]             palavras
);

  typedef enum logic [2:0] {
    StOcioso, StTamH, StTamL, StDados, StGrava, StSoma, StFim, StErro
  } state_e;

  localparam int unsigned MaxWords = PROF - BASE;

  state_e      state_q, state_d;
  logic [15:0] n_q;
  logic [1:0]  idx_q;
  logic [23:0] word_q;
  logic [7:0]  acc_q;
  logic [15:0] palavras_q;
  logic        op_q;
  logic [31:0] end_q;
  logic [31:0] instr_q;
  logic        ok_q;
  logic        erro_q;
  logic        ready_q;
  logic        busy_q;
  logic        xfer;

  function automatic logic is_ready(state_e s);
    return (s == StTamH) || (s == StTamL) || (s == StDados) || (s == StSoma);
  endfunction

  function automatic logic is_busy(state_e s);
    return !((s == StOcioso) || (s == StFim) || (s == StErro));
  endfunction

  // ready_q mirrors is_ready(state_q), so it doubles as the accept qualifier.
  assign xfer = bus.byte_valid && ready_q;

  // Next-state decode of the load sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOcioso, StFim, StErro: if (iniciar) state_d = StTamH;
      StTamH: if (xfer) state_d = StTamL;
      StTamL: begin
        if (xfer) begin
          if ({16'b0, n_q[15:8], bus.byte_in} > 32'(MaxWords)) state_d = StErro;
          else if ({n_q[15:8], bus.byte_in} == 16'd0)          state_d = StSoma;
          else                                                 state_d = StDados;
        end
      end
      StDados: if (xfer && idx_q == 2'd3) state_d = StGrava;
      StGrava: state_d = (palavras_q + 16'd1 == n_q) ? StSoma : StDados;
      StSoma: begin
        if (xfer) state_d = (bus.byte_in == acc_q) ? StFim : StErro;
      end
      default: state_d = StOcioso;
    endcase
  end

  // FSM state, datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clock_auto) begin
    if (!reset) begin
      state_q    <= StOcioso;
      n_q        <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      palavras_q <= '0;
      op_q       <= 1'b0;
      end_q      <= '0;
      instr_q    <= '0;
      ok_q       <= 1'b0;
      erro_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= is_ready(state_d);
      busy_q  <= is_busy(state_d);
      unique case (state_q)
        StOcioso, StFim, StErro: begin
          if (iniciar) begin
            ok_q       <= 1'b0;
            erro_q     <= 1'b0;
            palavras_q <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
          end
        end
        StTamH: if (xfer) n_q[15:8] <= bus.byte_in;
        StTamL: begin
          if (xfer) begin
            n_q[7:0] <= bus.byte_in;
            if (state_d == StErro) erro_q <= 1'b1;
          end
        end
        StDados: begin
          if (xfer) begin
            acc_q <= acc_q ^ bus.byte_in;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              instr_q <= {word_q, bus.byte_in};
              end_q   <= 32'(BASE) + {16'b0, palavras_q};
              op_q    <= 1'b1;
            end else begin
              word_q <= {word_q[15:0], bus.byte_in};
            end
          end
        end
        StGrava: begin
          op_q       <= 1'b0;
          palavras_q <= palavras_q + 16'd1;
        end
        StSoma: begin
          if (xfer) begin
            if (state_d == StFim) ok_q   <= 1'b1;
            else                  erro_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.OpMemIns   = op_q;
  assign bus.endLeitura = end_q;
  assign bus.instrucao  = instr_q;
  assign ocupado        = busy_q;
  assign carga_ok       = ok_q;
  assign erro           = erro_q;
  assign palavras       = palavras_q;

endmodule

// File: tb/tb_carga_programa.sv
// Directed bench for carga_programa: a per-cycle vector table for the nominal load
// with continuous byte_valid, then hand-written sequences for the corner cases.
module tb_carga_programa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iniciar;
  logic        ocupado, carga_ok, erro;
  logic [15:0] palavras;

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  carga_programa_if bus ();

  carga_programa #(
    .BASE (0),
    .PROF (16384)
  ) dut (
    .clock_auto (clk),
    .reset      (rst_n),
    .iniciar    (iniciar),
    .bus        (bus),
    .ocupado    (ocupado),
    .carga_ok   (carga_ok),
    .erro       (erro),
    .palavras   (palavras)
  );

  always #5 clk = ~clk;

  // Memory-side observer: OpMemIns lasts one full cycle, so each write is seen once.
  always @(negedge clk) begin
    if (bus.OpMemIns) begin
      wr_addr.push_back(bus.endLeitura);
      wr_data.push_back(bus.instrucao);
    end
  end

  typedef struct {
    logic        ini;
    logic        vld;
    logic [7:0]  din;
    logic        rdy;
    logic        op;
    logic [31:0] addr;
    logic [31:0] ins;
    logic        busy;
    logic        ok;
    logic        err;
    logic [15:0] pal;
  } vec_t;

  vec_t vecs[15];
  logic [7:0] nom[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " byte_ready"}, 32'(bus.byte_ready), 0);
    check({tag, " OpMemIns"},   32'(bus.OpMemIns), 0);
    check({tag, " endLeitura"}, bus.endLeitura, 0);
    check({tag, " instrucao"},  bus.instrucao, 0);
    check({tag, " ocupado"},    32'(ocupado), 0);
    check({tag, " carga_ok"},   32'(carga_ok), 0);
    check({tag, " erro"},       32'(erro), 0);
    check({tag, " palavras"},   32'(palavras), 0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus.byte_ready;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    if (!done) check("send_byte timeout", 0, 1);
  endtask

  task automatic start_load();
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic send_nominal(input logic [7:0] csum);
    for (int i = 0; i < 10; i++) send_byte(nom[i]);
    send_byte(csum);
  endtask

  task automatic check_nominal_writes(input string tag);
    check({tag, " write count"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({tag, " addr0"}, wr_addr[0], 32'd0);
      check({tag, " data0"}, wr_data[0], 32'h1234_5678);
      check({tag, " addr1"}, wr_addr[1], 32'd1);
      check({tag, " data1"}, wr_data[1], 32'hDEAD_BEEF);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    nom = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};

    // ini vld din  | rdy op addr ins busy ok err pal
    vecs[0]  = '{1, 0, 8'h00, 1, 0, 0, 32'h0,         1, 0, 0, 0};
    vecs[1]  = '{0, 1, 8'h00, 1, 0, 0, 32'h0,         1, 0, 0, 0};
    vecs[2]  = '{0, 1, 8'h02, 1, 0, 0, 32'h0,         1, 0, 0, 0};
    vecs[3]  = '{0, 1, 8'h12, 1, 0, 0, 32'h0,         1, 0, 0, 0};
    vecs[4]  = '{1, 1, 8'h34, 1, 0, 0, 32'h0,         1, 0, 0, 0}; // iniciar while busy
    vecs[5]  = '{0, 1, 8'h56, 1, 0, 0, 32'h0,         1, 0, 0, 0};
    vecs[6]  = '{0, 1, 8'h78, 0, 1, 0, 32'h1234_5678, 1, 0, 0, 0};
    vecs[7]  = '{0, 1, 8'hDE, 1, 0, 0, 32'h1234_5678, 1, 0, 0, 1}; // held in GRAVA
    vecs[8]  = '{0, 1, 8'hDE, 1, 0, 0, 32'h1234_5678, 1, 0, 0, 1};
    vecs[9]  = '{0, 1, 8'hAD, 1, 0, 0, 32'h1234_5678, 1, 0, 0, 1};
    vecs[10] = '{0, 1, 8'hBE, 1, 0, 0, 32'h1234_5678, 1, 0, 0, 1};
    vecs[11] = '{0, 1, 8'hEF, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 1};
    vecs[12] = '{0, 1, 8'h2A, 1, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 2}; // held in GRAVA
    vecs[13] = '{0, 1, 8'h2A, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 0, 2};
    vecs[14] = '{0, 0, 8'h00, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 0, 2};

    rst_n          = 1'b0;
    iniciar        = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    clear_writes();

    // Nominal load, byte_valid kept high across GRAVA cycles.
    for (int v = 0; v < 15; v++) begin
      iniciar        = vecs[v].ini;
      bus.byte_valid = vecs[v].vld;
      bus.byte_in    = vecs[v].din;
      @(negedge clk);
      check($sformatf("v%0d byte_ready", v), 32'(bus.byte_ready), 32'(vecs[v].rdy));
      check($sformatf("v%0d OpMemIns", v),   32'(bus.OpMemIns),   32'(vecs[v].op));
      check($sformatf("v%0d endLeitura", v), bus.endLeitura,      vecs[v].addr);
      check($sformatf("v%0d instrucao", v),  bus.instrucao,       vecs[v].ins);
      check($sformatf("v%0d ocupado", v),    32'(ocupado),        32'(vecs[v].busy));
      check($sformatf("v%0d carga_ok", v),   32'(carga_ok),       32'(vecs[v].ok));
      check($sformatf("v%0d erro", v),       32'(erro),           32'(vecs[v].err));
      check($sformatf("v%0d palavras", v),   32'(palavras),       32'(vecs[v].pal));
    end
    iniciar        = 1'b0;
    bus.byte_valid = 1'b0;
    check_nominal_writes("table");

    // Empty image.
    clear_writes();
    start_load();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("empty writes",   wr_addr.size(), 0);
    check("empty carga_ok", 32'(carga_ok), 1);
    check("empty erro",     32'(erro), 0);
    check("empty palavras", 32'(palavras), 0);
    check("empty ocupado",  32'(ocupado), 0);

    // Checksum mismatch: both words still written.
    clear_writes();
    start_load();
    send_nominal(8'h00);
    @(negedge clk);
    check_nominal_writes("badsum");
    check("badsum erro",     32'(erro), 1);
    check("badsum carga_ok", 32'(carga_ok), 0);
    check("badsum palavras", 32'(palavras), 2);

    // Oversize count 0x4001 > 16384.
    clear_writes();
    start_load();
    check("ini clears erro", 32'(erro), 0);
    send_byte(8'h40);
    send_byte(8'h01);
    check("oversize erro",       32'(erro), 1);
    check("oversize byte_ready", 32'(bus.byte_ready), 0);
    check("oversize ocupado",    32'(ocupado), 0);
    repeat (2) @(negedge clk);
    check("oversize writes", wr_addr.size(), 0);
    start_load();
    check("restart erro", 32'(erro), 0);
    send_nominal(8'h2A);
    @(negedge clk);
    check_nominal_writes("reload");
    check("reload carga_ok", 32'(carga_ok), 1);
    check("reload erro",     32'(erro), 0);

    // Reset while OpMemIns is high.
    start_load();
    for (int i = 0; i < 6; i++) send_byte(nom[i]);
    check("pre-reset OpMemIns", 32'(bus.OpMemIns), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    clear_writes();
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hDE;
    repeat (8) @(negedge clk);
    bus.byte_valid = 1'b0;
    check("post-reset writes",     wr_addr.size(), 0);
    check("post-reset byte_ready", 32'(bus.byte_ready), 0);
    check("post-reset palavras",   32'(palavras), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Hard stop in case a sequence stalls beyond its own bounds.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
